// File: rtl/bary_pkg.sv
// rtl/bary_pkg.sv - shared widths, FSM states and pixel type for the barycentre tracker
package bary_pkg;

    localparam int COORD_W = 9;
    localparam int CNT_W   = 19;
    localparam int SUM_W   = 27;

    typedef enum logic [1:0] {
        ACCUM,
        DIV,
        PUBLISH
    } bary_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring unsigned divider, one quotient bit per cycle, MSB first
// The first quotient bit is resolved in the start cycle, so done rises W cycles after start.
module seq_divider #(
    parameter int W   = 27,
    parameter int Q_W = W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [Q_W-1:0] quotient
);

    localparam int IW = $clog2(W + 1);
    localparam logic [IW-1:0] LAST = IW'(W - 1);

    logic [W-1:0]  rem, dq, div_q;
    logic [IW-1:0] iter;

    logic [W-1:0] src_rem, src_dq, src_div;
    logic [W:0]   trial;
    logic         ge;
    logic [W-1:0] rem_nxt, dq_nxt;

    // dq holds the unconsumed dividend bits on the left and the quotient bits on the right
    always_comb begin
        src_rem = start ? '0 : rem;
        src_dq  = start ? dividend : dq;
        src_div = start ? divisor : div_q;
        trial   = {src_rem, src_dq[W-1]};
        ge      = trial >= {1'b0, src_div};
        rem_nxt = ge ? (trial[W-1:0] - src_div) : trial[W-1:0];
        dq_nxt  = {src_dq[W-2:0], ge};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem   <= '0;
            dq    <= '0;
            div_q <= '0;
            iter  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem   <= rem_nxt;
                dq    <= dq_nxt;
                div_q <= divisor;
                iter  <= IW'(1);
                busy  <= 1'b1;
            end else if (busy) begin
                rem  <= rem_nxt;
                dq   <= dq_nxt;
                iter <= iter + IW'(1);
                if (iter == LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = dq[Q_W-1:0];

endmodule

// File: rtl/barycentre_tracker.sv
// rtl/barycentre_tracker.sv - per-frame centroid of lit pixels with a red cross overlay
// Accumulates lit-pixel sums, divides at the VGA_VS falling edge, publishes, and draws the cross.
module barycentre_tracker
    import bary_pkg::*;
#(
    parameter int THRESHOLD  = 128,
    parameter int MIN_PIXELS = 16,
    parameter int CROSS_HALF = 8
) (
    input  logic         VGA_CLK,
    input  logic         reset,
    input  logic         IMG,
    input  logic         VGA_VS,
    input  logic [8:0]   X_Cont,
    input  logic [8:0]   Y_Cont,
    input  logic [7:0]   r,
    input  logic [7:0]   g,
    input  logic [7:0]   b,
    output logic [7:0]   r_out,
    output logic [7:0]   g_out,
    output logic [7:0]   b_out,
    output logic         IMG_out,
    output logic [8:0]   bary_x,
    output logic [8:0]   bary_y,
    output logic         bary_valid,
    output logic         bary_done
);

    localparam logic [7:0]         THR     = THRESHOLD[7:0];
    localparam logic [CNT_W-1:0]   MIN_CNT = MIN_PIXELS[CNT_W-1:0];
    localparam logic [COORD_W-1:0] CH      = CROSS_HALF[COORD_W-1:0];

    bary_state_t state, state_nxt;

    logic             vs_q;
    logic             lit, frame_end, frame_take, enough;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SUM_W-1:0] sum_x, sum_y, sum_x_nxt, sum_y_nxt, divisor;
    logic             div_start, pub_skip, pub_div, div_done;
    logic             x_busy, y_busy, x_done, y_done;
    logic [COORD_W-1:0] qx, qy;

    // Sums include the current pixel so the frame-end cycle's pixel is not lost
    always_comb begin
        lit        = IMG && (r >= THR);
        frame_end  = vs_q && !VGA_VS;
        frame_take = frame_end && (state == ACCUM);
        cnt_nxt    = cnt + {{(CNT_W-1){1'b0}}, lit};
        sum_x_nxt  = sum_x + (lit ? {{(SUM_W-COORD_W){1'b0}}, X_Cont} : '0);
        sum_y_nxt  = sum_y + (lit ? {{(SUM_W-COORD_W){1'b0}}, Y_Cont} : '0);
        enough     = cnt_nxt >= MIN_CNT;
        divisor    = {{(SUM_W-CNT_W){1'b0}}, cnt_nxt};
        div_done   = x_done && y_done && !x_busy && !y_busy;
    end

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            vs_q  <= 1'b0;
            cnt   <= '0;
            sum_x <= '0;
            sum_y <= '0;
        end else begin
            vs_q <= VGA_VS;
            if (frame_take) begin
                cnt   <= '0;
                sum_x <= '0;
                sum_y <= '0;
            end else begin
                cnt   <= cnt_nxt;
                sum_x <= sum_x_nxt;
                sum_y <= sum_y_nxt;
            end
        end
    end

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) state <= ACCUM;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        pub_skip  = 1'b0;
        pub_div   = 1'b0;
        case (state)
            ACCUM: begin
                if (frame_take) begin
                    if (enough) begin
                        div_start = 1'b1;
                        state_nxt = DIV;
                    end else begin
                        pub_skip  = 1'b1;
                        state_nxt = PUBLISH;
                    end
                end
            end
            DIV: begin
                if (div_done) begin
                    pub_div   = 1'b1;
                    state_nxt = PUBLISH;
                end
            end
            PUBLISH: state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    seq_divider #(.W(SUM_W), .Q_W(COORD_W)) u_div_x (
        .clk      (VGA_CLK),
        .reset    (reset),
        .start    (div_start),
        .dividend (sum_x_nxt),
        .divisor  (divisor),
        .busy     (x_busy),
        .done     (x_done),
        .quotient (qx)
    );

    seq_divider #(.W(SUM_W), .Q_W(COORD_W)) u_div_y (
        .clk      (VGA_CLK),
        .reset    (reset),
        .start    (div_start),
        .dividend (sum_y_nxt),
        .divisor  (divisor),
        .busy     (y_busy),
        .done     (y_done),
        .quotient (qy)
    );

    // Result registers load on the edge entering PUBLISH, so they are valid while bary_done is high
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            bary_x     <= '0;
            bary_y     <= '0;
            bary_valid <= 1'b0;
            bary_done  <= 1'b0;
        end else begin
            bary_done <= pub_skip || pub_div;
            if (pub_skip) begin
                bary_valid <= 1'b0;
            end else if (pub_div) begin
                bary_x     <= qx;
                bary_y     <= qy;
                bary_valid <= 1'b1;
            end
        end
    end

    logic [COORD_W-1:0] dx, dy;
    logic               on_cross;
    pixel_t             pix_nxt, pix_q;
    logic               img_q;

    always_comb begin
        dx       = (X_Cont >= bary_x) ? (X_Cont - bary_x) : (bary_x - X_Cont);
        dy       = (Y_Cont >= bary_y) ? (Y_Cont - bary_y) : (bary_y - Y_Cont);
        on_cross = bary_valid && (((Y_Cont == bary_y) && (dx <= CH)) ||
                                  ((X_Cont == bary_x) && (dy <= CH)));
        pix_nxt  = '0;
        if (IMG) begin
            if (on_cross) pix_nxt = '{r: 8'hFF, g: 8'h00, b: 8'h00};
            else          pix_nxt = '{r: r, g: g, b: b};
        end
    end

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            pix_q <= '0;
            img_q <= 1'b0;
        end else begin
            pix_q <= pix_nxt;
            img_q <= IMG;
        end
    end

    assign r_out   = pix_q.r;
    assign g_out   = pix_q.g;
    assign b_out   = pix_q.b;
    assign IMG_out = img_q;

endmodule
